// File: rtl/stack_arb.sv
// Round-robin arbiter/sequencer sharing one stack datapath between N_REQ requesters.
// Optional BUSY watchdog enabled by defining STACK_ARB_TIMEOUT_EN.
module stack_arb #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*DATA_W-1:0]   req_data_wr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         req_data_rd,
  output logic                      req_err,
  output logic [N_REQ-1:0]          grant,
  output logic                      stk_valid,
  input  logic                      stk_ready,
  output logic                      stk_write,
  output logic [DATA_W-1:0]         stk_data_wr,
  input  logic [DATA_W-1:0]         stk_data_rd,
  input  logic                      stk_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("stack_arb: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("stack_arb: TIMEOUT_CYC must be in 2..255");
  end

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [N_REQ-1:0]      ready_q, ready_d;
  logic [DATA_W-1:0]     data_rd_q, data_rd_d;
  logic                  err_q, err_d;
  logic                  stk_valid_q, stk_valid_d;
  logic                  stk_write_q, stk_write_d;
  logic [DATA_W-1:0]     stk_data_wr_q, stk_data_wr_d;
`ifdef STACK_ARB_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`endif

  logic                  any_valid_c;
  logic [IDX_W-1:0]      cand_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  hs_c;
  logic [DATA_W-1:0]     wr_arr [N_REQ];

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
    assign wr_arr[g] = req_data_wr[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid requester at or after ptr_q, wrapping.
  always_comb begin
    any_valid_c = 1'b0;
    cand_c      = '0;
    win_idx_c   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand_c = IDX_W'((int'(ptr_q) + i) % int'(N_REQ));
      if (!any_valid_c && req_valid[cand_c]) begin
        any_valid_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  assign hs_c = stk_valid_q && stk_ready;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    grant_d       = grant_q;
    ready_d       = '0;
    data_rd_d     = data_rd_q;
    err_d         = err_q;
    stk_valid_d   = stk_valid_q;
    stk_write_d   = stk_write_q;
    stk_data_wr_d = stk_data_wr_q;
`ifdef STACK_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_valid_c) begin
          win_d         = win_idx_c;
          grant_d       = N_REQ'(1) << win_idx_c;
          stk_write_d   = req_write[win_idx_c];
          stk_data_wr_d = wr_arr[win_idx_c];
          stk_valid_d   = 1'b1;
          state_d       = S_BUSY;
`ifdef STACK_ARB_TIMEOUT_EN
          cnt_d         = 8'd0;
`endif
        end
      end
      S_BUSY: begin
        if (hs_c) begin
          data_rd_d   = stk_data_rd;
          err_d       = stk_err;
          stk_valid_d = 1'b0;
          ready_d     = grant_q;
          ptr_d       = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
          state_d     = S_DONE;
        end
`ifdef STACK_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          // Limit reached without a handshake: abort with an error completion.
          if (cnt_q + 8'd1 == 8'(TIMEOUT_CYC)) begin
            data_rd_d   = '0;
            err_d       = 1'b1;
            stk_valid_d = 1'b0;
            ready_d     = grant_q;
            ptr_d       = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            state_d     = S_DONE;
          end
        end
`endif
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d     = '0;
        stk_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      grant_q       <= '0;
      ready_q       <= '0;
      data_rd_q     <= '0;
      err_q         <= 1'b0;
      stk_valid_q   <= 1'b0;
      stk_write_q   <= 1'b0;
      stk_data_wr_q <= '0;
`ifdef STACK_ARB_TIMEOUT_EN
      cnt_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      grant_q       <= grant_d;
      ready_q       <= ready_d;
      data_rd_q     <= data_rd_d;
      err_q         <= err_d;
      stk_valid_q   <= stk_valid_d;
      stk_write_q   <= stk_write_d;
      stk_data_wr_q <= stk_data_wr_d;
`ifdef STACK_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign req_data_rd = data_rd_q;
  assign req_err     = err_q;
  assign grant       = grant_q;
  assign stk_valid   = stk_valid_q;
  assign stk_write   = stk_write_q;
  assign stk_data_wr = stk_data_wr_q;

endmodule

// File: tb/tb_stack_arb.sv
// Directed self-checking bench for stack_arb (N_REQ=4, DATA_W=32, TIMEOUT_CYC=16).
module tb_stack_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_write;
  logic [N*W-1:0] req_data_wr;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   req_data_rd;
  logic           req_err;
  logic [N-1:0]   grant;
  logic           stk_valid;
  logic           stk_ready;
  logic           stk_write;
  logic [W-1:0]   stk_data_wr;
  logic [W-1:0]   stk_data_rd;
  logic           stk_err;

  int errors = 0;
  int checks = 0;

  stack_arb #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_data_wr(req_data_wr),
    .req_ready(req_ready), .req_data_rd(req_data_rd), .req_err(req_err),
    .grant(grant),
    .stk_valid(stk_valid), .stk_ready(stk_ready), .stk_write(stk_write),
    .stk_data_wr(stk_data_wr), .stk_data_rd(stk_data_rd), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_data_wr = '0;
    stk_ready   = 1'b0;
    stk_data_rd = '0;
    stk_err     = 1'b0;

    // Reset values
    #12;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_data_rd", 64'(req_data_rd), 64'h0);
    chk("rst_err", 64'(req_err), 64'h0);
    chk("rst_stk_valid", 64'(stk_valid), 64'h0);
    chk("rst_stk_write", 64'(stk_write), 64'h0);
    chk("rst_stk_data_wr", 64'(stk_data_wr), 64'h0);
    reset_n = 1'b1;
    step();

    // Single push from requester 1, stk_ready tied high
    stk_ready = 1'b1;
    req_valid = 4'b0010;
    req_write = 4'b0010;
    req_data_wr[1*W +: W] = 32'hA5A5_0001;
    step();
    chk("push_stk_valid", 64'(stk_valid), 64'h1);
    chk("push_stk_data_wr", 64'(stk_data_wr), 64'hA5A5_0001);
    chk("push_stk_write", 64'(stk_write), 64'h1);
    chk("push_grant", 64'(grant), 64'b0010);
    chk("push_ready_early", 64'(req_ready), 64'h0);
    step();
    chk("push_ready", 64'(req_ready), 64'b0010);
    chk("push_err", 64'(req_err), 64'h0);
    chk("push_stk_valid_done", 64'(stk_valid), 64'h0);
    req_valid = '0;
    step();
    chk("push_ready_pulse", 64'(req_ready), 64'h0);
    chk("push_grant_idle", 64'(grant), 64'h0);

    // Pop from requester 0 with wait states
    stk_ready   = 1'b0;
    stk_data_rd = 32'h0000_1234;
    req_valid   = 4'b0001;
    req_write   = 4'b0000;
    step();
    chk("pop_stk_valid", 64'(stk_valid), 64'h1);
    chk("pop_grant", 64'(grant), 64'b0001);
    chk("pop_stk_write", 64'(stk_write), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pop_wait_valid", 64'(stk_valid), 64'h1);
      chk("pop_wait_ready", 64'(req_ready), 64'h0);
    end
    stk_ready = 1'b1;
    step();
    chk("pop_ready", 64'(req_ready), 64'b0001);
    chk("pop_data", 64'(req_data_rd), 64'h1234);
    stk_ready   = 1'b0;
    req_valid   = '0;
    stk_data_rd = 32'hFFFF_0000;
    step();
    chk("pop_ready_pulse", 64'(req_ready), 64'h0);
    chk("pop_data_hold", 64'(req_data_rd), 64'h1234);

    // Reset while BUSY on requester 2
    req_valid = 4'b0100;
    req_write = 4'b0100;
    step();
    chk("mid_busy_grant", 64'(grant), 64'b0100);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_stk_valid", 64'(stk_valid), 64'h0);
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    req_valid = '0;
    #2 reset_n = 1'b1;

    // Fairness after reset: all valid, requester 0 first, then 1,2,3,0,...
    stk_ready = 1'b1;
    stk_data_rd = '0;
    req_write = 4'b0101;
    for (int i = 0; i < int'(N); i++) req_data_wr[i*W +: W] = 32'h1000_0000 + 32'(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      chk("rr_grant", 64'(grant), 64'(exp_g));
      chk("rr_stk_data_wr", 64'(stk_data_wr), 64'h1000_0000 + 64'(k % 4));
      chk("rr_stk_write", 64'(stk_write), 64'((k % 2) == 0));
      step();
      chk("rr_ready", 64'(req_ready), 64'(exp_g));
      step();
      chk("rr_ready_single", 64'(req_ready), 64'h0);
    end
    req_valid = '0;
    step();

    // Error propagation: pop by requester 3 on empty stack, then a clean op
    req_valid   = 4'b1000;
    req_write   = 4'b0000;
    stk_data_rd = 32'hDEAD_BEEF;
    step();
    chk("err_grant", 64'(grant), 64'b1000);
    stk_err = 1'b1;
    step();
    chk("err_ready", 64'(req_ready), 64'b1000);
    chk("err_flag", 64'(req_err), 64'h1);
    chk("err_data", 64'(req_data_rd), 64'hDEAD_BEEF);
    stk_err   = 1'b0;
    req_write = 4'b1000;
    step();
    step();
    chk("err_next_grant", 64'(grant), 64'b1000);
    step();
    chk("err_next_ready", 64'(req_ready), 64'b1000);
    chk("err_next_flag", 64'(req_err), 64'h0);
    req_valid = '0;
    step();

`ifdef STACK_ARB_TIMEOUT_EN
    // Timeout: stk_ready held low for 16 BUSY cycles
    stk_ready   = 1'b0;
    stk_data_rd = 32'h5555_5555;
    req_valid   = 4'b0001;
    req_write   = 4'b0000;
    step();
    chk("to_stk_valid_first", 64'(stk_valid), 64'h1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_stk_valid_busy", 64'(stk_valid), 64'h1);
    end
    step();
    chk("to_stk_valid_drop", 64'(stk_valid), 64'h0);
    chk("to_ready", 64'(req_ready), 64'b0001);
    chk("to_err", 64'(req_err), 64'h1);
    chk("to_data", 64'(req_data_rd), 64'h0);
    req_valid = '0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_arb.md
# stack_arb

Round-robin arbiter and sequencer that shares one stack datapath (valid/ready, write, data_wr/data_rd, err) between N_REQ requesters. It sits between the requester agents and the stack. It serialises operations one at a time and registers the winning payload toward the stack. It returns read data and the error flag to the requester that issued the operation.

## Interface
- N_REQ, 4: number of requesters, legal 2..8
- DATA_W, 32: stack data width
- TIMEOUT_CYC, 16: BUSY cycles before abort; legal 2..255; only used with STACK_ARB_TIMEOUT_EN
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request; held high with payload stable until matching req_ready
- req_write  in  N_REQ  1 = push, 0 = pop
- req_data_wr  in  N_REQ*DATA_W  push data; requester i uses bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot, one-cycle completion pulse
- req_data_rd  out  DATA_W  pop result; valid while req_ready is high, then held
- req_err  out  1  error for the completing operation; valid while req_ready is high
- grant  out  N_REQ  one-hot current owner; 0 in IDLE
- stk_valid  out  1  operation request to stack
- stk_ready  in  1  stack accepts/completes the operation
- stk_write  out  1  registered copy of winner's req_write
- stk_data_wr  out  DATA_W  registered copy of winner's push data
- stk_data_rd  in  DATA_W  stack pop data, sampled on handshake
- stk_err  in  1  stack overflow/underflow, sampled on handshake

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - if any req_valid, pick a winner by round-robin, starting the search at pointer ptr.
  - Register grant, stk_write and stk_data_wr; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stk_valid = 1.
  - On a cycle with stk_valid && stk_ready: capture stk_data_rd into req_data_rd and stk_err into req_err; go to DONE.
  - ptr = (winner + 1) mod N_REQ, updated when leaving BUSY.
- DONE:
  - req_ready[winner] = 1 for exactly this cycle; stk_valid = 0.
  - New requests are not evaluated. Next state is IDLE, and grant clears on that transition.
- Pop (req_write = 0): req_data_rd = stk_data_rd. Push: req_data_rd = stk_data_rd as returned (don't-care to requester).
- Requester protocol:
  - A requester drops req_valid in the cycle after its req_ready, or keeps it high to queue the next operation.
  - Dropping req_valid during BUSY is a violation. The operation still completes and req_ready still pulses.
- Fairness: with all requesters continuously valid, grant order from reset is 0,1,2,...,N_REQ-1,0,...

## Timing
- Reset values:
  - state IDLE, ptr 0.
  - grant 0, req_ready 0, req_data_rd 0, req_err 0.
  - stk_valid 0, stk_write 0, stk_data_wr 0.
- Reset is asynchronous and takes effect immediately, including mid-BUSY. The aborted operation produces no req_ready.
- Cycle sequence for a request sampled in IDLE at cycle t:
  - stk_valid is high from t+1.
  - Handshake at cycle t+k (k ≥ 1).
  - req_ready pulses at t+k+1.
  - IDLE again at t+k+2.
- Minimum latency from req_valid to req_ready is 2 cycles. Peak throughput is one operation per 3 cycles.
- stk_valid, stk_write and stk_data_wr are held stable from BUSY entry until the handshake.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.

## Configuration
- STACK_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on BUSY entry and increments every BUSY cycle without a handshake.
  - When the count reaches TIMEOUT_CYC: drop stk_valid, go to DONE, req_err = 1, req_data_rd = 0.
  - If the handshake occurs in the same cycle the limit is reached, the handshake wins and is completed normally.
- STACK_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for stk_ready; TIMEOUT_CYC is ignored.

## Test plan
- Single push:
  - Stimulus: requester 1 pushes 0xA5A5_0001; stk_ready tied to 1.
  - Required: stk_valid at t+1 with stk_data_wr = 0xA5A5_0001; req_ready = 0b0010 at t+2; req_err = 0.
- Pop with wait states:
  - Stimulus: requester 0 pops; stk_ready is raised 4 cycles after stk_valid; stk_data_rd = 0x1234.
  - Required: req_ready[0] pulses one cycle after the handshake; req_data_rd = 0x1234.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid for 8 operations.
  - Required: grant sequence 0,1,2,3,0,1,2,3; each req_ready is a single cycle.
- Error propagation:
  - Stimulus: pop on an empty stack, with stk_err = 1 at the handshake.
  - Required: req_err = 1 coincident with req_ready; the next operation reports req_err = 0.
- Reset mid-operation:
  - Stimulus: assert reset_n = 0 while in BUSY.
  - Required: stk_valid, grant and req_ready go to 0 immediately; after release, a request from requester 0 is served first.
- Timeout (STACK_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16):
  - Stimulus: stk_ready held at 0.
  - Required: stk_valid is dropped after 16 BUSY cycles; req_ready pulses with req_err = 1 and req_data_rd = 0.
